// File: rtl/control_unit.sv
// Multicycle sequencer: fetches a 16-bit word, decodes it in EXEC and
// drives accumulator/register-file strobes and the program counter.
module control_unit (
  input  logic        Clock,
  input  logic        nReset,
  input  logic [15:0] ProgData,
  input  logic [7:0]  ACC,
  input  logic [7:0]  SW,
  output logic [7:0]  PC,
  output logic [7:0]  Imm,
  output logic [2:0]  RegAddr,
  output logic        AccWE,
  output logic        RegWE,
  output logic        SelImm,
  output logic        SelSW,
  output logic        SelRegData,
  output logic        UseACC,
  output logic        Halted,
  output logic        Illegal
);

  typedef enum logic [1:0] {
    FETCH,
    EXEC,
    WAIT,
    HALT
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LDI   = 4'h1;
  localparam logic [3:0] OP_LDSW  = 4'h2;
  localparam logic [3:0] OP_LDR   = 4'h3;
  localparam logic [3:0] OP_ADDI  = 4'h4;
  localparam logic [3:0] OP_ADDR  = 4'h5;
  localparam logic [3:0] OP_MULI  = 4'h6;
  localparam logic [3:0] OP_STR   = 4'h7;
  localparam logic [3:0] OP_JMP   = 4'h8;
  localparam logic [3:0] OP_BZ    = 4'h9;
  localparam logic [3:0] OP_WAIT  = 4'hA;
  localparam logic [3:0] OP_HALT  = 4'hB;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] ir;
  logic [3:0]  op;
  logic [7:0]  pc_nxt;
  logic [7:0]  pc_inc;
  logic        ill_set;
  logic        go;
  logic        acc_zero;

  assign op       = ir[15:12];
  assign Imm      = ir[7:0];
  assign RegAddr  = ir[11:9];
  assign pc_inc   = PC + 8'd1;
  assign go       = SW[7];
  assign acc_zero = (ACC == 8'h00);
  assign Halted   = (state == HALT);

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state   <= FETCH;
      PC      <= 8'h00;
      ir      <= 16'h0000;
      Illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      PC    <= pc_nxt;
      if (state == FETCH)
        ir <= ProgData;
      if (ill_set)
        Illegal <= 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = PC;
    ill_set    = 1'b0;
    AccWE      = 1'b0;
    RegWE      = 1'b0;
    SelImm     = 1'b0;
    SelSW      = 1'b0;
    SelRegData = 1'b0;
    UseACC     = 1'b0;
    unique case (state)
      FETCH: state_nxt = EXEC;
      EXEC: begin
        state_nxt = FETCH;
        pc_nxt    = pc_inc;
        case (op)
          OP_NOP: ;
          OP_LDI: begin
            AccWE  = 1'b1;
            SelImm = 1'b1;
          end
          OP_LDSW: begin
            AccWE = 1'b1;
            SelSW = 1'b1;
          end
          OP_LDR: begin
            AccWE      = 1'b1;
            SelRegData = 1'b1;
          end
          OP_ADDI: begin
            AccWE  = 1'b1;
            UseACC = 1'b1;
            SelImm = 1'b1;
          end
          OP_ADDR: begin
            AccWE      = 1'b1;
            UseACC     = 1'b1;
            SelRegData = 1'b1;
          end
          OP_MULI: begin
            AccWE  = 1'b1;
            UseACC = 1'b1;
          end
          OP_STR: RegWE = 1'b1;
          OP_JMP: pc_nxt = ir[7:0];
          OP_BZ: begin
            if (acc_zero)
              pc_nxt = ir[7:0];
          end
          OP_WAIT: begin
            // Go already high: skip the WAIT state entirely
            if (!go) begin
              state_nxt = WAIT;
              pc_nxt    = PC;
            end
          end
          OP_HALT: begin
            state_nxt = HALT;
            pc_nxt    = PC;
          end
          default: ill_set = 1'b1;
        endcase
      end
      WAIT: begin
        if (go) begin
          state_nxt = FETCH;
          pc_nxt    = pc_inc;
        end
      end
      HALT: ;
      default: state_nxt = FETCH;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: ROM model, per-feature tasks,
// plus a negedge monitor for select and halt invariants.
module tb_control_unit;

  logic        Clock = 1'b0;
  logic        nReset;
  logic [15:0] ProgData;
  logic [7:0]  ACC;
  logic [7:0]  SW;
  logic [7:0]  PC;
  logic [7:0]  Imm;
  logic [2:0]  RegAddr;
  logic        AccWE;
  logic        RegWE;
  logic        SelImm;
  logic        SelSW;
  logic        SelRegData;
  logic        UseACC;
  logic        Halted;
  logic        Illegal;

  logic [15:0] rom [256];
  logic [5:0]  strb;
  int          checks = 0;
  int          errors = 0;

  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_LDI  = 6'b101000;
  localparam logic [5:0] S_LDSW = 6'b100100;
  localparam logic [5:0] S_ADDI = 6'b101001;
  localparam logic [5:0] S_ADDR = 6'b100011;
  localparam logic [5:0] S_MULI = 6'b100001;
  localparam logic [5:0] S_STR  = 6'b010000;

  always #5 Clock = ~Clock;

  assign ProgData = rom[PC];
  assign strb = {AccWE, RegWE, SelImm, SelSW, SelRegData, UseACC};

  control_unit dut (
    .Clock      (Clock),
    .nReset     (nReset),
    .ProgData   (ProgData),
    .ACC        (ACC),
    .SW         (SW),
    .PC         (PC),
    .Imm        (Imm),
    .RegAddr    (RegAddr),
    .AccWE      (AccWE),
    .RegWE      (RegWE),
    .SelImm     (SelImm),
    .SelSW      (SelSW),
    .SelRegData (SelRegData),
    .UseACC     (UseACC),
    .Halted     (Halted),
    .Illegal    (Illegal)
  );

  always @(negedge Clock) begin
    if (nReset) begin
      checks++;
      if (($countones({SelImm, SelSW, SelRegData}) > 1) ||
          (Halted && strb != S_NONE)) begin
        errors++;
        $display("FAIL invariant sel=%b%b%b halted=%b strb=%b",
                 SelImm, SelSW, SelRegData, Halted, strb);
      end
    end
  end

  task automatic do_reset();
    nReset = 1'b0;
    ACC = 8'h00;
    SW  = 8'h00;
    for (int i = 0; i < 256; i++)
      rom[i] = 16'h0000;
    @(negedge Clock);
    @(negedge Clock);
  endtask

  task automatic release_reset();
    nReset = 1'b1;
  endtask

  task automatic step();
    @(negedge Clock);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({PC, Imm, RegAddr, Halted, Illegal} !== 21'd0 ||
        strb !== S_NONE) begin
      errors++;
      $display("FAIL reset_state pc=%h imm=%h ra=%h h=%b i=%b strb=%b",
               PC, Imm, RegAddr, Halted, Illegal, strb);
    end
  endtask

  task automatic test_sequence();
    do_reset();
    rom[0] = 16'h1005;
    rom[1] = 16'h4003;
    rom[2] = 16'h7400;
    release_reset();
    step();
    checks++;
    if (strb !== S_LDI || Imm !== 8'h05) begin
      errors++;
      $display("FAIL seq_ldi strb=%b imm=%h expected %b 05",
               strb, Imm, S_LDI);
    end
    step();
    checks++;
    if (strb !== S_NONE || PC !== 8'h01) begin
      errors++;
      $display("FAIL seq_fetch1 strb=%b pc=%h expected 000000 01",
               strb, PC);
    end
    step();
    checks++;
    if (strb !== S_ADDI || Imm !== 8'h03) begin
      errors++;
      $display("FAIL seq_addi strb=%b imm=%h expected %b 03",
               strb, Imm, S_ADDI);
    end
    step();
    step();
    checks++;
    if (strb !== S_STR || RegAddr !== 3'd2) begin
      errors++;
      $display("FAIL seq_str strb=%b ra=%0d expected %b 2",
               strb, RegAddr, S_STR);
    end
    step();
    checks++;
    if (PC !== 8'h03 || strb !== S_NONE) begin
      errors++;
      $display("FAIL seq_pc pc=%h strb=%b expected 03 000000",
               PC, strb);
    end
  endtask

  task automatic test_branch();
    do_reset();
    rom[0]    = 16'h9040;
    rom[8'h40] = 16'h9010;
    rom[8'h41] = 16'h80FF;
    release_reset();
    step();
    checks++;
    if (strb !== S_NONE) begin
      errors++;
      $display("FAIL bz_strobe strb=%b expected 000000", strb);
    end
    step();
    checks++;
    if (PC !== 8'h40) begin
      errors++;
      $display("FAIL bz_taken pc=%h expected 40", PC);
    end
    ACC = 8'h01;
    step();
    step();
    checks++;
    if (PC !== 8'h41) begin
      errors++;
      $display("FAIL bz_not_taken pc=%h expected 41", PC);
    end
    step();
    step();
    checks++;
    if (PC !== 8'hFF) begin
      errors++;
      $display("FAIL jmp pc=%h expected ff", PC);
    end
    step();
    step();
    checks++;
    if (PC !== 8'h00) begin
      errors++;
      $display("FAIL pc_wrap pc=%h expected 00", PC);
    end
  endtask

  task automatic test_wait();
    do_reset();
    rom[0] = 16'hA000;
    rom[1] = 16'hA000;
    rom[2] = 16'h1001;
    release_reset();
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (PC !== 8'h00 || strb !== S_NONE) begin
        errors++;
        $display("FAIL wait_hold%0d pc=%h strb=%b expected 00 000000",
                 i, PC, strb);
      end
    end
    SW = 8'h80;
    step();
    checks++;
    if (PC !== 8'h01) begin
      errors++;
      $display("FAIL wait_release pc=%h expected 01", PC);
    end
    step();
    step();
    checks++;
    if (PC !== 8'h02 || strb !== S_NONE) begin
      errors++;
      $display("FAIL wait_skip pc=%h strb=%b expected 02 000000",
               PC, strb);
    end
    step();
    checks++;
    if (strb !== S_LDI) begin
      errors++;
      $display("FAIL wait_skip_exec strb=%b expected %b", strb, S_LDI);
    end
  endtask

  task automatic test_halt();
    do_reset();
    rom[0] = 16'h8007;
    rom[7] = 16'hB000;
    release_reset();
    step();
    step();
    step();
    checks++;
    if (Halted !== 1'b0 || PC !== 8'h07) begin
      errors++;
      $display("FAIL halt_exec halted=%b pc=%h expected 0 07",
               Halted, PC);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (Halted !== 1'b1 || PC !== 8'h07 || strb !== S_NONE) begin
        errors++;
        $display("FAIL halt_hold%0d h=%b pc=%h strb=%b expected 1 07 0",
                 i, Halted, PC, strb);
      end
    end
    #2;
    nReset = 1'b0;
    #1;
    checks++;
    if (Halted !== 1'b0 || PC !== 8'h00 || strb !== S_NONE) begin
      errors++;
      $display("FAIL halt_reset h=%b pc=%h strb=%b expected 0 00 0",
               Halted, PC, strb);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    rom[0] = 16'hE000;
    rom[1] = 16'h1009;
    rom[2] = 16'h5600;
    rom[3] = 16'h2000;
    rom[4] = 16'h6000;
    SW = 8'h80;
    release_reset();
    step();
    checks++;
    if (strb !== S_NONE || Illegal !== 1'b0) begin
      errors++;
      $display("FAIL ill_exec strb=%b ill=%b expected 000000 0",
               strb, Illegal);
    end
    step();
    checks++;
    if (Illegal !== 1'b1 || PC !== 8'h01) begin
      errors++;
      $display("FAIL ill_set ill=%b pc=%h expected 1 01", Illegal, PC);
    end
    step();
    checks++;
    if (strb !== S_LDI || Illegal !== 1'b1) begin
      errors++;
      $display("FAIL ill_ldi strb=%b ill=%b expected %b 1",
               strb, Illegal, S_LDI);
    end
    step();
    step();
    checks++;
    if (strb !== S_ADDR || RegAddr !== 3'd3) begin
      errors++;
      $display("FAIL addr strb=%b ra=%0d expected %b 3",
               strb, RegAddr, S_ADDR);
    end
    step();
    step();
    checks++;
    if (strb !== S_LDSW) begin
      errors++;
      $display("FAIL ldsw strb=%b expected %b", strb, S_LDSW);
    end
    step();
    step();
    checks++;
    if (strb !== S_MULI || Illegal !== 1'b1) begin
      errors++;
      $display("FAIL muli strb=%b ill=%b expected %b 1",
               strb, Illegal, S_MULI);
    end
    do_reset();
    checks++;
    if (Illegal !== 1'b0) begin
      errors++;
      $display("FAIL ill_clear ill=%b expected 0", Illegal);
    end
  endtask

  initial begin
    nReset = 1'b0;
    test_reset();
    test_sequence();
    test_branch();
    test_wait();
    test_halt();
    test_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
